// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the Tetris VGA renderer:
//   - 640x480@60 timing constants (totals, front porches, sync widths)
//   - playfield geometry in cells and the border thickness
//   - cell_t  : 4-bit cell code held in each playfield square (0 = empty)
//   - rgb_t   : 12-bit {r,g,b} colour
//   - palette : maps a cell code to its display colour
// ---------------------------------------------------------------------------
package tetris_pkg;

   localparam int H_ACTIVE  = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_TOTAL   = 800;
   localparam int V_ACTIVE  = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_TOTAL   = 525;

   localparam int GRID_ROWS = 20;
   localparam int GRID_COLS = 10;
   localparam int BORDER_PX = 4;

   typedef logic [3:0]  cell_t;
   typedef logic [11:0] rgb_t;

   localparam rgb_t BORDER_RGB = 12'h888;

   // Codes 8..15 are not real pieces; they all show as white so that
   // anything unexpected in the grid is still visible on screen.
   function automatic rgb_t palette(input cell_t code);
      case (code)
         4'd0:    palette = 12'h000;
         4'd1:    palette = 12'h0FF;
         4'd2:    palette = 12'hFF0;
         4'd3:    palette = 12'hA0F;
         4'd4:    palette = 12'hF80;
         4'd5:    palette = 12'h00F;
         4'd6:    palette = 12'h0F0;
         4'd7:    palette = 12'hF00;
         default: palette = 12'hFFF;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel-rate enable and 800x525 raster counters for 640x480@60.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   pix_ce    : one clk cycle high in every PIX_DIV cycles
//   h_cnt     : horizontal position 0..799, advances on pix_ce
//   v_cnt     : vertical position 0..524, advances when h_cnt wraps
//   hs_pulse  : high while h_cnt is inside the horizontal sync window
//   vs_pulse  : high while v_cnt is inside the vertical sync window
//   active    : high inside the 640x480 visible area
// ---------------------------------------------------------------------------
module vga_timing
   import tetris_pkg::*;
#(
   parameter int PIX_DIV = 4
)(
   input  logic       clk,
   input  logic       rst,
   output logic       pix_ce,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       hs_pulse,
   output logic       vs_pulse,
   output logic       active
);

   localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt;

   // The enable fires on the last count, so the first pixel step after
   // reset release lands exactly PIX_DIV clocks later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign pix_ce = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign hs_pulse = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_pulse = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);

endmodule

// File: rtl/tetris_vga_render.sv
// ---------------------------------------------------------------------------
// tetris_vga_render
// Draws a 10x20 Tetris playfield with a grey border on a 640x480 VGA raster.
// Ports:
//   gm_clk      : single clock, everything on its rising edge
//   gm_rst      : asynchronous active-high reset
//   grid        : cell codes [row][col], row 0 at top, col 0 at left, 0 = empty
//   vga_hs/vs   : active-low syncs, delayed to line up with the colour
//   vga_r/g/b   : 4-bit colour channels
//   frame_tick  : one gm_clk pulse when pixel (0,0) reaches the outputs
// Build option:
//   TETRIS_GRIDLINES_EN - when defined, empty cells get a dim grey line on
//   their top row and left column of pixels.
// ---------------------------------------------------------------------------
module tetris_vga_render
   import tetris_pkg::*;
#(
   parameter int PIX_DIV  = 4,
   parameter int CELL_PX  = 20,
   parameter int FIELD_X0 = 220,
   parameter int FIELD_Y0 = 40
)(
   input  logic                                  gm_clk,
   input  logic                                  gm_rst,
   input  cell_t [GRID_ROWS-1:0][GRID_COLS-1:0] grid,
   output logic                                  vga_hs,
   output logic                                  vga_vs,
   output logic [3:0]                            vga_r,
   output logic [3:0]                            vga_g,
   output logic [3:0]                            vga_b,
   output logic                                  frame_tick
);

   localparam int               OFF_W    = $clog2(CELL_PX);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CELL_PX - 1);
   localparam logic [9:0]       FX0      = 10'(FIELD_X0);
   localparam logic [9:0]       FX1      = 10'(FIELD_X0 + GRID_COLS * CELL_PX);
   localparam logic [9:0]       FY0      = 10'(FIELD_Y0);
   localparam logic [9:0]       FY1      = 10'(FIELD_Y0 + GRID_ROWS * CELL_PX);
   localparam logic [9:0]       BX0      = 10'(FIELD_X0 - BORDER_PX);
   localparam logic [9:0]       BX1      = 10'(FIELD_X0 + GRID_COLS * CELL_PX + BORDER_PX);
   localparam logic [9:0]       BY0      = 10'(FIELD_Y0 - BORDER_PX);
   localparam logic [9:0]       BY1      = 10'(FIELD_Y0 + GRID_ROWS * CELL_PX + BORDER_PX);
   localparam logic [9:0]       FX_PRE   = 10'(FIELD_X0 - 1);
   localparam logic [9:0]       FY_PRE   = 10'(FIELD_Y0 - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_SNAP   = 10'(V_ACTIVE);

   logic       pix_ce;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       hs_pulse;
   logic       vs_pulse;
   logic       active;

   vga_timing #(
      .PIX_DIV (PIX_DIV)
   ) u_timing (
      .clk      (gm_clk),
      .rst      (gm_rst),
      .pix_ce   (pix_ce),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .hs_pulse (hs_pulse),
      .vs_pulse (vs_pulse),
      .active   (active)
   );

   cell_t [GRID_ROWS-1:0][GRID_COLS-1:0] fb;

   // The whole grid is copied once, on the first blanking line, so the
   // visible frame always comes from one consistent game state.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         fb <= '0;
      end else if (pix_ce && (h_cnt == 10'd0) && (v_cnt == V_SNAP)) begin
         fb <= grid;
      end
   end

   logic [OFF_W-1:0] x_off;
   logic [OFF_W-1:0] y_off;
   logic [3:0]       col;
   logic [4:0]       row;

   // Cell coordinates are tracked by counters that run alongside h_cnt and
   // v_cnt; they are rearmed one step before the playfield edge so they read
   // col/row 0, offset 0 exactly on the first playfield pixel. Outside the
   // playfield their values are meaningless and never used.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         x_off <= '0;
         col   <= '0;
         y_off <= '0;
         row   <= '0;
      end else if (pix_ce) begin
         if (h_cnt == FX_PRE) begin
            x_off <= '0;
            col   <= '0;
         end else if (x_off == OFF_LAST) begin
            x_off <= '0;
            col   <= col + 4'd1;
         end else begin
            x_off <= x_off + OFF_W'(1);
         end
         if (h_cnt == H_LAST) begin
            if (v_cnt == FY_PRE) begin
               y_off <= '0;
               row   <= '0;
            end else if (y_off == OFF_LAST) begin
               y_off <= '0;
               row   <= row + 5'd1;
            end else begin
               y_off <= y_off + OFF_W'(1);
            end
         end
      end
   end

   logic in_field;
   logic in_frame;

   assign in_field = (h_cnt >= FX0) && (h_cnt < FX1) && (v_cnt >= FY0) && (v_cnt < FY1);
   assign in_frame = (h_cnt >= BX0) && (h_cnt < BX1) && (v_cnt >= BY0) && (v_cnt < BY1);

   cell_t s1_code;
   logic  s1_field;
   logic  s1_border;
   logic  s1_active;
   logic  s1_hsync;
   logic  s1_vsync;
   logic  s1_first;

   // Stage 1: cell lookup. Syncs travel as active-high flags so a cleared
   // pipeline means "no sync", keeping the outputs idle after reset.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         s1_code   <= '0;
         s1_field  <= 1'b0;
         s1_border <= 1'b0;
         s1_active <= 1'b0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_first  <= 1'b0;
      end else if (pix_ce) begin
         s1_code   <= in_field ? fb[row][col] : cell_t'(0);
         s1_field  <= in_field;
         s1_border <= in_frame && !in_field;
         s1_active <= active;
         s1_hsync  <= hs_pulse;
         s1_vsync  <= vs_pulse;
         s1_first  <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end
   end

`ifdef TETRIS_GRIDLINES_EN
   localparam rgb_t GRIDLINE_RGB = 12'h333;

   logic s1_gline;

   // Gridline marks the first pixel column and row of every cell.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         s1_gline <= 1'b0;
      end else if (pix_ce) begin
         s1_gline <= (x_off == '0) || (y_off == '0);
      end
   end
`endif

   rgb_t pix_rgb;

   // Stage 2 colour choice: playfield palette first, then the border ring,
   // black everywhere else including blanking.
   always_comb begin
      pix_rgb = '0;
      if (s1_active) begin
         if (s1_field) begin
            pix_rgb = palette(s1_code);
`ifdef TETRIS_GRIDLINES_EN
            if ((s1_code == cell_t'(0)) && s1_gline) begin
               pix_rgb = GRIDLINE_RGB;
            end
`endif
         end else if (s1_border) begin
            pix_rgb = BORDER_RGB;
         end
      end
   end

   // Stage 2 register. frame_tick is sampled every clock so it stays high
   // for exactly the one gm_clk cycle in which pixel (0,0) is presented.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         vga_hs     <= 1'b1;
         vga_vs     <= 1'b1;
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= pix_ce && s1_first;
         if (pix_ce) begin
            vga_hs                <= ~s1_hsync;
            vga_vs                <= ~s1_vsync;
            {vga_r, vga_g, vga_b} <= pix_rgb;
         end
      end
   end

endmodule

// File: tb/tb_tetris_vga_render.sv
// ---------------------------------------------------------------------------
// tb_tetris_vga_render
// Directed bench for tetris_vga_render running at PIX_DIV = 2. The bench
// counts gm_clk edges since reset release itself; pixel (x,y) of frame f
// reaches the outputs on edge ((f*800*525 + y*800 + x) + 2) * PIX_DIV.
// Colour expectations follow TETRIS_GRIDLINES_EN if the bench is built
// with it.
// ---------------------------------------------------------------------------
module tb_tetris_vga_render;

   localparam int DIV       = 2;
   localparam int H_TOT     = 800;
   localparam int V_TOT     = 525;
   localparam int FRAME_PIX = H_TOT * V_TOT;

`ifdef TETRIS_GRIDLINES_EN
   localparam logic [11:0] GL = 12'h333;
`else
   localparam logic [11:0] GL = 12'h000;
`endif

   logic                   clk;
   logic                   rst;
   logic [19:0][9:0][3:0]  grid;
   logic                   vga_hs;
   logic                   vga_vs;
   logic [3:0]             vga_r;
   logic [3:0]             vga_g;
   logic [3:0]             vga_b;
   logic                   frame_tick;

   int checks;
   int errors;
   int edge_n;
   int lowCnt;
   int highCnt;

   tetris_vga_render #(
      .PIX_DIV  (DIV),
      .CELL_PX  (20),
      .FIELD_X0 (220),
      .FIELD_Y0 (40)
   ) dut (
      .gm_clk     (clk),
      .gm_rst     (rst),
      .grid       (grid),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .frame_tick (frame_tick)
   );

   // 10 ns gm_clk
   always #5 clk = ~clk;

   // Edge count since the last reset release; edge 1 is the first rising
   // edge after release.
   always @(posedge clk or posedge rst) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   task automatic applyStimulus(input int r, input int c, input logic [3:0] code);
      grid[r][c] = code;
   endtask

   task automatic waitEdge(input int target);
      if (edge_n > target) begin
         errors++;
         $display("[TB] FAIL schedule: already at edge %0d, required edge %0d", edge_n, target);
      end
      while (edge_n < target) @(negedge clk);
   endtask

   task automatic waitPixel(input int f, input int x, input int y);
      waitEdge((f * FRAME_PIX + y * H_TOT + x + 2) * DIV);
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] expRgb);
      logic [11:0] obs;
      obs = {vga_r, vga_g, vga_b};
      checks++;
      assert (obs === expRgb) else begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, expRgb);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic checkSync(input string tag, input logic obs, input logic expBit);
      checks++;
      assert (obs === expBit) else begin
         errors++;
         $display("[TB] FAIL %s: observed %b expected %b", tag, obs, expBit);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic checkCount(input string tag, input int obs, input int expCnt);
      checks++;
      assert (obs == expCnt) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expCnt);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst    = 1'b1;
      grid   = '0;
      checks = 0;
      errors = 0;

      // Reset values while gm_rst is held
      repeat (3) @(negedge clk);
      checkSync("rst_hs", vga_hs, 1'b1);
      checkSync("rst_vs", vga_vs, 1'b1);
      checkOutput("rst_rgb", 12'h000);
      checkSync("rst_tick", frame_tick, 1'b0);
      rst = 1'b0;

      // Pulse reset with the raster at h=300, v=100
      waitEdge((100 * H_TOT + 300) * DIV);
      rst = 1'b1;
      #1;
      checkSync("pulse_hs", vga_hs, 1'b1);
      checkSync("pulse_vs", vga_vs, 1'b1);
      checkOutput("pulse_rgb", 12'h000);
      checkSync("pulse_tick", frame_tick, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Timing restarts at (0,0); frame_tick two pixel steps after release
      waitEdge(2 * DIV - 1);
      checkSync("tick_early", frame_tick, 1'b0);
      waitEdge(2 * DIV);
      checkSync("tick_restart", frame_tick, 1'b1);
      waitEdge(2 * DIV + 1);
      checkSync("tick_width", frame_tick, 1'b0);

      // Game state for the first snapshot
      applyStimulus(0, 0, 4'd1);
      applyStimulus(19, 9, 4'd7);
      applyStimulus(5, 5, 4'd9);

      // Horizontal sync: 96 pixels low in an 800-pixel line
      waitPixel(0, 655, 0);
      checkSync("hs_before", vga_hs, 1'b1);
      waitPixel(0, 656, 0);
      lowCnt = 0;
      while (vga_hs === 1'b0 && lowCnt < 10000) begin
         lowCnt++;
         @(negedge clk);
      end
      highCnt = 0;
      while (vga_hs === 1'b1 && highCnt < 10000) begin
         highCnt++;
         @(negedge clk);
      end
      checkCount("hs_low", lowCnt, 96 * DIV);
      checkCount("hs_period", lowCnt + highCnt, H_TOT * DIV);

      // Frame 0 still shows the empty buffer from reset
      waitPixel(0, 220, 40);
      checkOutput("f0_220_40", GL);
      waitPixel(0, 221, 41);
      checkOutput("f0_221_41", 12'h000);
      waitPixel(0, 218, 100);
      checkOutput("f0_border", 12'h888);
      waitPixel(0, 700, 100);
      checkOutput("f0_700_100", 12'h000);

      // Vertical sync: low for lines 490 and 491
      waitPixel(0, 799, 489);
      checkSync("vs_before", vga_vs, 1'b1);
      waitPixel(0, 0, 490);
      lowCnt = 0;
      while (vga_vs === 1'b0 && lowCnt < 20000) begin
         lowCnt++;
         @(negedge clk);
      end
      checkCount("vs_low", lowCnt, 2 * H_TOT * DIV);

      // Frame period
      waitEdge((FRAME_PIX + 2) * DIV - 1);
      checkSync("f1_tick_early", frame_tick, 1'b0);
      waitPixel(1, 0, 0);
      checkSync("f1_tick", frame_tick, 1'b1);

      // Frame 1 shows the snapshot
      waitPixel(1, 219, 40);
      checkOutput("f1_219_40", 12'h888);
      waitPixel(1, 220, 40);
      checkOutput("f1_220_40", 12'h0FF);
      waitPixel(1, 240, 40);
      checkOutput("f1_240_40", GL);
      waitPixel(1, 239, 59);
      checkOutput("f1_239_59", 12'h0FF);
      waitPixel(1, 300, 60);
      checkOutput("f1_300_60", GL);
      waitPixel(1, 301, 61);
      checkOutput("f1_301_61", 12'h000);
      waitPixel(1, 218, 100);
      checkOutput("f1_218_100", 12'h888);
      waitPixel(1, 700, 100);
      checkOutput("f1_700_100", 12'h000);
      waitPixel(1, 330, 150);
      checkOutput("f1_330_150", 12'hFFF);

      // Mid-frame grid change must wait for the next snapshot
      waitPixel(1, 0, 200);
      applyStimulus(10, 3, 4'd2);
      waitPixel(1, 280, 240);
      checkOutput("f1_280_240", GL);
      waitPixel(1, 419, 439);
      checkOutput("f1_419_439", 12'hF00);
      waitPixel(1, 420, 439);
      checkOutput("f1_420_439", 12'h888);

      // Frame 2 shows the changed cell
      waitPixel(2, 280, 240);
      checkOutput("f2_280_240", 12'hFF0);
      waitPixel(2, 299, 259);
      checkOutput("f2_299_259", 12'hFF0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tetris_vga_render.md
TETRIS_VGA_RENDER -- requirements
Module: tetris_vga_render

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4, meaning gm_clk cycles per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameter CELL_PX, default 20, meaning the side in pixels of one square cell.
REQ-003 SHALL have parameter FIELD_X0, default 220, meaning the playfield left pixel column.
REQ-004 SHALL have parameter FIELD_Y0, default 40, meaning the playfield top pixel line.
REQ-005 SHALL have port gm_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port gm_rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port grid, input, 4 bits x [19:0][9:0]: cell codes, row 0 at top, col 0 at left, 0 meaning empty.
REQ-008 SHALL have port vga_hs, output, 1 bit: horizontal sync, active-low.
REQ-009 SHALL have port vga_vs, output, 1 bit: vertical sync, active-low.
REQ-010 SHALL have ports vga_r, vga_g and vga_b, output, 4 bits each: pixel colour.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-gm_clk pulse at the start of each frame.

Function
REQ-012 SHALL generate pix_ce internally, one gm_clk cycle high in every PIX_DIV cycles; all counters and pipeline stages advance only on pix_ce.
REQ-013 SHALL run h_cnt 0..799 and v_cnt 0..524; h_cnt wraps to 0 and increments v_cnt; v_cnt wraps 524 to 0.
REQ-014 SHALL define the active area as h<640 and v<480; hsync is low for h 656..751; vsync is low for v 490..491.
REQ-015 SHALL snapshot all 200 grid cells into an internal frame buffer on the pix_ce where h=0 and v=480, with no other update, so a frame never tears.
REQ-016 SHALL map a playfield pixel, FIELD_X0<=x<FIELD_X0+10*CELL_PX and FIELD_Y0<=y<FIELD_Y0+20*CELL_PX, to col=(x-FIELD_X0)/CELL_PX and row=(y-FIELD_Y0)/CELL_PX, using cell/offset sub-counters and no divider.
REQ-017 SHALL use palette {r,g,b} hex: code 0=000, 1=0FF, 2=FF0, 3=A0F, 4=F80, 5=00F, 6=0F0, 7=F00, 8..15=FFF.
REQ-018 SHALL output border colour 888 for pixels within 4 px outside the playfield rectangle and not inside it.
REQ-019 SHALL output 000 for all other active pixels and for all pixels outside the active area.
REQ-020 SHALL register the outputs through a 2-stage pipeline (cell lookup, then palette), with vga_hs and vga_vs delayed by the same 2 pix_ce stages so that sync and colour stay aligned.
REQ-021 SHALL assert frame_tick on the pix_ce cycle where h=0 and v=0 enter stage 0.

Reset
REQ-022 SHALL, on gm_rst assertion, immediately set: divider, h_cnt, v_cnt and pipeline contents to 0; frame buffer all 0; vga_hs=1, vga_vs=1, RGB=000, frame_tick=0.
REQ-023 SHALL, after gm_rst releases mid-frame, restart timing at h=0, v=0, with the first pix_ce PIX_DIV cycles after release.

Configuration
REQ-024 SHALL, with macro TETRIS_GRIDLINES_EN defined, draw empty-cell pixels at cell offset x=0 or y=0 as 333.
REQ-025 SHALL, without TETRIS_GRIDLINES_EN, draw empty cells as 000 and include no gridline logic.

Structure
REQ-026 SHALL take timing constants (800/525, porches, sync widths), the palette function and the cell-code type from shared package tetris_pkg.
REQ-027 SHALL place sync timing in a sub-module vga_timing (pix_ce, h_cnt, v_cnt, raw syncs, active flag); snapshot, mapping and palette stay in tetris_vga_render.

Verification
REQ-028 SHALL cover reset release: vga_hs period is 3200 gm_clk cycles, low for 384 cycles; vga_vs low for 2 lines (6400 gm_clk cycles); frame period 1,680,000 cycles.
REQ-029 SHALL cover grid[0][0]=1 with all other cells 0: pixels x220..239, y40..59 are 0FF; pixel (240,40) is 000; pixel (218,100) is 888; pixel (700,100) is 000.
REQ-030 SHALL cover grid[19][9]=7 and grid[5][5]=9: pixel (419,439) is F00; pixel (330,150) is FFF.
REQ-031 SHALL cover changing grid[10][3] from 0 to 2 at v=200: the change is not visible in the current frame, and pixel (280,240) is FF0 in the next frame.
REQ-032 SHALL cover gm_rst pulsed at h=300, v=100: same cycle vga_hs=1, vga_vs=1, RGB=000; frame_tick occurs 2 pix_ce after timing restarts.
REQ-033 SHALL cover TETRIS_GRIDLINES_EN defined with an empty grid: pixel (220,40) is 333 and pixel (221,41) is 000; without the macro both are 000.
